mux_4_1_sync: RTL and testbench

//  4-to-1 data multiplexer with a combinational path and a registered path.

---
 rtl/mux_4_1_sync_if.sv | 27 ++
 rtl/mux_4_1_sync.sv | 45 ++++
 tb/tb_mux_4_1_sync.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mux_4_1_sync_if.sv
// Bus bundle for the 4-to-1 multiplexer: four data words, select, capture
// qualifier, and the combinational and registered results.
interface mux_4_1_sync_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [1:0]       s;
  logic             in_valid;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             y_valid;

  // Source side: supplies data/select and observes both results.
  modport master (
    output d0, d1, d2, d3, s, in_valid,
    input  y, y_q, y_valid
  );

  // Multiplexer side: consumes data/select and produces both results.
  modport slave (
    input  d0, d1, d2, d3, s, in_valid,
    output y, y_q, y_valid
  );
endinterface

// File: rtl/mux_4_1_sync.sv
// 4-to-1 multiplexer with a zero-latency combinational output and a
// one-cycle registered output qualified by in_valid.
module mux_4_1_sync #(
  parameter int WIDTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_4_1_sync_if.slave bus
);

  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] data_p0;
  logic             vld_p0;

  // Select one word; an unknown select propagates as all-X in simulation.
  always_comb begin
    sel_word = 'x;
    case (bus.s)
      2'b00:   sel_word = bus.d0;
      2'b01:   sel_word = bus.d1;
      2'b10:   sel_word = bus.d2;
      2'b11:   sel_word = bus.d3;
      default: sel_word = 'x;
    endcase
  end

  assign bus.y = sel_word;

  // Stage p0: capture the selected word when qualified; hold it otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= bus.in_valid;
      if (bus.in_valid) begin
        data_p0 <= sel_word;
      end
    end
  end

  assign bus.y_q     = data_p0;
  assign bus.y_valid = vld_p0;

endmodule

// File: tb/tb_mux_4_1_sync.sv
// Directed bench for mux_4_1_sync: WIDTH=2 instance for the fixed-pattern
// steps and WIDTH=8 instance for the random-data select sweep.
module tb_mux_4_1_sync;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  mux_4_1_sync_if #(.WIDTH(2)) bus2 ();
  mux_4_1_sync_if #(.WIDTH(8)) bus8 ();

  mux_4_1_sync #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  mux_4_1_sync #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] w [4];
    logic [1:0] seq [4];
    logic [1:0] exp2;
    tests = 0;
    fails = 0;
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;

    rst_n = 1'b0;
    bus2.d0 = 2'b00; bus2.d1 = 2'b01; bus2.d2 = 2'b10; bus2.d3 = 2'b11;
    bus2.s = 2'b00; bus2.in_valid = 1'b0;
    bus8.d0 = 8'h00; bus8.d1 = 8'h00; bus8.d2 = 8'h00; bus8.d3 = 8'h00;
    bus8.s = 2'b00; bus8.in_valid = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check("rst_y_q", {6'd0, bus2.y_q}, 8'h00);
    check("rst_y_valid", {7'd0, bus2.y_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Step 1: combinational path, each select held 20 ns
    for (int i = 0; i < 4; i++) begin
      bus2.s = seq[i];
      #1;
      check("comb_y", {6'd0, bus2.y}, {6'd0, seq[i]});
      #19;
    end

    // Step 2: registered path, one select per clock
    @(negedge clk);
    bus2.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus2.s = seq[i];
      @(posedge clk); #1;
      check("reg_y_q", {6'd0, bus2.y_q}, {6'd0, seq[i]});
      check("reg_y_valid", {7'd0, bus2.y_valid}, 8'h01);
      @(negedge clk);
    end

    // Step 3: capture 11, then two idle cycles hold it
    bus2.s = 2'b11;
    @(posedge clk); #1;
    check("hold_cap", {6'd0, bus2.y_q}, 8'h03);
    @(negedge clk);
    bus2.in_valid = 1'b0;
    bus2.s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("hold_y_q", {6'd0, bus2.y_q}, 8'h03);
      check("hold_y_valid", {7'd0, bus2.y_valid}, 8'h00);
    end

    // Step 4: asynchronous reset between edges while y_q=10
    @(negedge clk);
    bus2.in_valid = 1'b1;
    bus2.s = 2'b10;
    @(posedge clk); #1;
    check("pre_rst_y_q", {6'd0, bus2.y_q}, 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_y_q", {6'd0, bus2.y_q}, 8'h00);
    check("async_rst_y_valid", {7'd0, bus2.y_valid}, 8'h00);
    bus2.s = 2'b01;
    #1;
    check("rst_y_tracks", {6'd0, bus2.y}, 8'h01);
    @(posedge clk); #1;
    check("rst_held_y_q", {6'd0, bus2.y_q}, 8'h00);
    check("rst_held_y_valid", {7'd0, bus2.y_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    bus2.s = 2'b10;
    @(posedge clk); #1;
    check("post_rst_y_q", {6'd0, bus2.y_q}, 8'h02);
    check("post_rst_y_valid", {7'd0, bus2.y_valid}, 8'h01);

    // Step 5: change d2 with s=10 and capture disabled
    @(negedge clk);
    bus2.in_valid = 1'b0;
    bus2.d2 = 2'b01;
    #1;
    check("d2_change_y", {6'd0, bus2.y}, 8'h01);
    @(posedge clk); #1;
    check("d2_change_y_q", {6'd0, bus2.y_q}, 8'h02);
    @(negedge clk);
    bus2.d2 = 2'b10;

    // Step 6: WIDTH=8 sweep with random data
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) w[k] = 8'($urandom_range(0, 255));
        bus8.d0 = w[0]; bus8.d1 = w[1]; bus8.d2 = w[2]; bus8.d3 = w[3];
        bus8.s = 2'(i);
        bus8.in_valid = 1'b1;
        #1;
        check("w8_y", bus8.y, w[i]);
        @(posedge clk); #1;
        check("w8_y_q", bus8.y_q, w[i]);
        check("w8_y_valid", {7'd0, bus8.y_valid}, 8'h01);
      end
    end

    // Select changes between edges never disturb the registered output
    @(negedge clk);
    bus8.in_valid = 1'b0;
    exp2 = 2'b11;
    bus2.s = 2'b01;
    #1;
    bus2.s = exp2;
    #1;
    check("mid_cycle_y", {6'd0, bus2.y}, 8'h03);
    check("mid_cycle_y_q", {6'd0, bus2.y_q}, 8'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
